// File: rtl/leaf_uplink_arbiter_pkg.sv
// Shared definitions for the root-hub uplink path: beat width, arbiter state
// encoding and the source-index width helper.
package hub_pkg;

   localparam int DATA_W = 64;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // A single leaf still needs a 1-bit source tag.
   function automatic int src_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/leaf_uplink_arbiter_if.sv
// Leaf-side input streams and merged output stream of the uplink arbiter.
// slave is the arbiter's view; master is the view of whatever drives the leaves.
interface leaf_uplink_arbiter_if #(
   parameter int NUM_LEAVES = 2,
   parameter int DATA_W     = hub_pkg::DATA_W,
   parameter int SRC_W      = hub_pkg::src_w(NUM_LEAVES)
);
   logic [DATA_W*NUM_LEAVES-1:0] in_data;
   logic [NUM_LEAVES-1:0]        in_valid;
   logic [NUM_LEAVES-1:0]        in_last;
   logic [NUM_LEAVES-1:0]        in_ready;
   logic [DATA_W-1:0]            out_data;
   logic [SRC_W-1:0]             out_src;
   logic                         out_last;
   logic                         out_valid;
   logic                         out_ready;

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_src, out_last, out_valid
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_src, out_last, out_valid
   );

endinterface

// File: rtl/leaf_uplink_arbiter_pick.sv
// Round-robin priority picker: first requester at or after ptr, wrapping.
// Purely combinational; the doubled request vector handles the wrap.
module rr_priority_pick #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] index,
   output logic          any
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [PW:0]    sum;
   int             off;

   always_comb begin
      dbl   = {req, req};
      rot   = N'(dbl >> ptr);
      off   = 0;
      any   = 1'b0;
      // Scanning downwards leaves the lowest offset from ptr as the winner.
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = k;
            any = 1'b1;
         end
      end
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(N)) begin
         sum = sum - (PW+1)'(N);
      end
      index = sum[PW-1:0];
      grant = any ? (N'(1) << index) : '0;
   end

endmodule

// File: rtl/leaf_uplink_arbiter.sv
// Merges NUM_LEAVES leaf streams into one registered, source-tagged stream
// with round-robin, message-atomic arbitration.
module leaf_uplink_arbiter #(
   parameter int NUM_LEAVES = 2,
   parameter int DATA_W     = hub_pkg::DATA_W,
   parameter int CNT_W      = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   leaf_uplink_arbiter_if.slave    bus,
   output logic [CNT_W-1:0]        msg_count,
   output logic                    busy
);
   import hub_pkg::*;

   localparam int SRC_W = src_w(NUM_LEAVES);
   localparam logic [0:0] ST_IDLE   = IDLE;
   localparam logic [0:0] ST_LOCKED = LOCKED;

   logic [0:0]            state;
   logic [SRC_W-1:0]      rr_ptr;
   logic [SRC_W-1:0]      lock_id;

   logic [NUM_LEAVES-1:0] pick_grant;
   logic [SRC_W-1:0]      pick_idx;
   logic                  pick_any;

   logic                  locked;
   logic                  slot_free;
   logic [NUM_LEAVES-1:0] sel_onehot;
   logic [SRC_W-1:0]      sel_id;
   logic [DATA_W-1:0]     sel_data;
   logic                  sel_valid;
   logic                  sel_last;
   logic                  accept;

   function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] id);
      return (id == SRC_W'(NUM_LEAVES - 1)) ? '0 : id + 1'b1;
   endfunction

   rr_priority_pick #(
      .N  (NUM_LEAVES),
      .PW (SRC_W)
   ) u_pick (
      .req   (bus.in_valid),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .index (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      locked     = (state == ST_LOCKED);
      slot_free  = !bus.out_valid || bus.out_ready;
      sel_id     = locked ? lock_id : pick_idx;
      sel_onehot = locked ? (NUM_LEAVES'(1) << lock_id) : pick_grant;
      sel_valid  = |(sel_onehot & bus.in_valid);
      sel_last   = |(sel_onehot & bus.in_last);
      sel_data   = '0;
      for (int i = 0; i < NUM_LEAVES; i++) begin
         if (sel_onehot[i]) begin
            sel_data = bus.in_data[i*DATA_W +: DATA_W];
         end
      end
      // in_ready is forced low while reset is held so no leaf sees a phantom accept.
      accept       = sel_valid && slot_free && reset;
      bus.in_ready = (reset && slot_free) ? sel_onehot : '0;
      busy         = locked;
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values of its peers, regardless of block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         rr_ptr  <= '0;
         lock_id <= '0;
      end else if (accept) begin
         if (locked) begin
            if (sel_last) begin
               state  <= ST_IDLE;
               rr_ptr <= wrap_inc(lock_id);
            end
         end else if (sel_last) begin
            rr_ptr <= wrap_inc(pick_idx);
         end else begin
            state   <= ST_LOCKED;
            lock_id <= pick_idx;
         end
      end
   end

   // Accept and drain in the same cycle simply reloads the register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_src   <= '0;
         bus.out_last  <= 1'b0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= sel_data;
         bus.out_src   <= sel_id;
         bus.out_last  <= sel_last;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         msg_count <= '0;
      end else if (bus.out_valid && bus.out_ready && bus.out_last) begin
         msg_count <= msg_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// Directed scoreboard bench for leaf_uplink_arbiter (2 leaves, 4-bit counter):
// a feeder drives per-leaf beat queues, a monitor checks every output handshake.
module tb_leaf_uplink_arbiter;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } beat_t;

   typedef struct packed {
      logic [63:0] data;
      logic        src;
      logic        last;
   } exp_t;

   localparam int LIMIT = 200;

   logic       clk;
   logic       reset;
   logic [3:0] msg_count;
   logic       busy;

   leaf_uplink_arbiter_if #(.NUM_LEAVES(2), .DATA_W(64), .SRC_W(1)) bus ();

   leaf_uplink_arbiter #(
      .NUM_LEAVES (2),
      .DATA_W     (64),
      .CNT_W      (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .msg_count (msg_count),
      .busy      (busy)
   );

   beat_t lq0[$];
   beat_t lq1[$];
   exp_t  exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   logic [3:0] exp_cnt = 4'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   task automatic send(input int leaf, input logic [63:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      if (leaf == 0) lq0.push_back(b);
      else           lq1.push_back(b);
   endtask

   task automatic expect_beat(input logic [63:0] d, input logic s, input logic l);
      exp_t e;
      e.data = d;
      e.src  = s;
      e.last = l;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string name);
      int cyc;
      cyc = 0;
      while ((exp_q.size() > 0 || lq0.size() > 0 || lq1.size() > 0) && cyc < LIMIT) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check(name, 64'(cyc >= LIMIT), 64'd0);
   endtask

   task automatic wait_out_valid(input string name);
      int cyc;
      cyc = 0;
      while (!bus.out_valid && cyc < LIMIT) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check(name, 64'(cyc >= LIMIT), 64'd0);
   endtask

   // Feeder: presents each leaf queue head, pops it once the edge accepted it.
   initial begin
      logic [1:0] acc;
      bus.in_valid = '0;
      bus.in_data  = '0;
      bus.in_last  = '0;
      forever begin
         bus.in_valid[0] = (lq0.size() > 0);
         if (lq0.size() > 0) begin
            bus.in_data[63:0] = lq0[0].data;
            bus.in_last[0]    = lq0[0].last;
         end
         bus.in_valid[1] = (lq1.size() > 0);
         if (lq1.size() > 0) begin
            bus.in_data[127:64] = lq1[0].data;
            bus.in_last[1]      = lq1[0].last;
         end
         @(negedge clk);
         acc = bus.in_valid & bus.in_ready;
         @(posedge clk);
         #1;
         if (reset) begin
            if (acc[0] && lq0.size() > 0) lq0.delete(0);
            if (acc[1] && lq1.size() > 0) lq1.delete(0);
         end
      end
   end

   // Monitor: every output handshake is matched against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            exp_cnt = 4'd0;
         end else if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got src %0d data 0x%0h, want no beat",
                        bus.out_src, bus.out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_data", bus.out_data, e.data);
               check("out_src", 64'(bus.out_src), 64'(e.src));
               check("out_last", 64'(bus.out_last), 64'(e.last));
               check("msg_count_at_beat", 64'(msg_count), 64'(exp_cnt));
               if (e.last) exp_cnt = exp_cnt + 4'd1;
            end
         end
      end
   end

   initial begin
      int busy_cnt;
      int stall_bad;
      int cyc;

      reset         = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", bus.out_data, 64'd0);
      check("rst_out_src", 64'(bus.out_src), 64'd0);
      check("rst_out_last", 64'(bus.out_last), 64'd0);
      check("rst_msg_count", 64'(msg_count), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      reset = 1'b1;

      // Single 1-beat message from leaf 1, one cycle of latency.
      @(negedge clk);
      send(1, 64'hDEAD_BEEF, 1'b1);
      expect_beat(64'hDEAD_BEEF, 1'b1, 1'b1);
      cyc = 0;
      do begin
         @(negedge clk);
         #1;
         cyc++;
      end while (!(bus.in_valid[1] && bus.in_ready[1]) && cyc < LIMIT);
      check("t1_accept_timeout", 64'(cyc >= LIMIT), 64'd0);
      @(negedge clk);
      check("t1_latency_valid", 64'(bus.out_valid), 64'd1);
      check("t1_latency_src", 64'(bus.out_src), 64'd1);
      wait_drain("t1_drain_timeout");
      @(negedge clk);
      #1;
      check("t1_msg_count", 64'(msg_count), 64'd1);

      // Both leaves always valid with 1-beat messages: 0,1,0,1 back to back.
      @(negedge clk);
      send(0, 64'hA0, 1'b1);
      send(1, 64'hB0, 1'b1);
      send(0, 64'hA1, 1'b1);
      send(1, 64'hB1, 1'b1);
      expect_beat(64'hA0, 1'b0, 1'b1);
      expect_beat(64'hB0, 1'b1, 1'b1);
      expect_beat(64'hA1, 1'b0, 1'b1);
      expect_beat(64'hB1, 1'b1, 1'b1);
      wait_out_valid("t2_valid_timeout");
      for (int k = 0; k < 4; k++) begin
         check("t2_throughput_valid", 64'(bus.out_valid), 64'd1);
         check("t2_alternate_src", 64'(bus.out_src), 64'(k % 2));
         @(negedge clk);
         #1;
      end
      wait_drain("t2_drain_timeout");

      // 3-beat message from leaf 0 holds the grant against a waiting leaf 1.
      @(negedge clk);
      send(0, 64'hC0, 1'b0);
      send(0, 64'hC1, 1'b0);
      send(0, 64'hC2, 1'b1);
      send(1, 64'hD0, 1'b1);
      expect_beat(64'hC0, 1'b0, 1'b0);
      expect_beat(64'hC1, 1'b0, 1'b0);
      expect_beat(64'hC2, 1'b0, 1'b1);
      expect_beat(64'hD0, 1'b1, 1'b1);
      busy_cnt  = 0;
      stall_bad = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         #1;
         if (busy) busy_cnt++;
         if (busy && bus.in_ready[1]) stall_bad++;
      end
      check("t3_busy_cycles", 64'(busy_cnt), 64'd2);
      check("t3_leaf1_stalled", 64'(stall_bad), 64'd0);
      wait_drain("t3_drain_timeout");

      // Downstream back-pressure: held beat stable, then drain + accept together.
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      send(0, 64'hE0E0_1234, 1'b1);
      expect_beat(64'hE0E0_1234, 1'b0, 1'b1);
      wait_out_valid("t4_valid_timeout");
      send(1, 64'hF0F0_5678, 1'b1);
      expect_beat(64'hF0F0_5678, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         check("t4_hold_data", bus.out_data, 64'hE0E0_1234);
         check("t4_hold_valid", 64'(bus.out_valid), 64'd1);
         check("t4_stall_in_ready", 64'(bus.in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      #1;
      check("t4_drain_accept_ready", 64'(bus.in_ready), 64'b10);
      check("t4_drain_held_data", bus.out_data, 64'hE0E0_1234);
      @(negedge clk);
      #1;
      check("t4_new_beat_valid", 64'(bus.out_valid), 64'd1);
      check("t4_new_beat_src", 64'(bus.out_src), 64'd1);
      wait_drain("t4_drain_timeout");

      // Move rr_ptr to 1, then abort a locked burst with reset after beat 2.
      @(negedge clk);
      send(0, 64'h6060, 1'b1);
      expect_beat(64'h6060, 1'b0, 1'b1);
      wait_drain("t5_pre_drain_timeout");
      @(negedge clk);
      send(0, 64'h7070_0000, 1'b0);
      send(0, 64'h7070_0001, 1'b0);
      send(0, 64'h7070_0002, 1'b1);
      expect_beat(64'h7070_0000, 1'b0, 1'b0);
      expect_beat(64'h7070_0001, 1'b0, 1'b0);
      cyc = 0;
      while (exp_q.size() > 0 && cyc < LIMIT) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check("t5_beat2_timeout", 64'(cyc >= LIMIT), 64'd0);
      reset = 1'b0;
      #1;
      check("t5_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("t5_rst_out_data", bus.out_data, 64'd0);
      check("t5_rst_out_src", 64'(bus.out_src), 64'd0);
      check("t5_rst_out_last", 64'(bus.out_last), 64'd0);
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("t5_rst_msg_count", 64'(msg_count), 64'd0);
      lq0.delete();
      lq1.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      send(0, 64'h8080, 1'b1);
      send(1, 64'h9090, 1'b1);
      expect_beat(64'h8080, 1'b0, 1'b1);
      expect_beat(64'h9090, 1'b1, 1'b1);
      wait_drain("t5_post_drain_timeout");

      // 14 more messages makes 16 since reset: the 4-bit counter wraps to 0.
      @(negedge clk);
      for (int k = 0; k < 14; k++) begin
         send(0, 64'h1000 + 64'(k), 1'b1);
         expect_beat(64'h1000 + 64'(k), 1'b0, 1'b1);
      end
      wait_drain("t6_drain_timeout");
      @(negedge clk);
      #1;
      check("t6_msg_count_wrap", 64'(msg_count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
